// File: rtl/link_sync_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : link_sync_pkg
// Purpose  : Shared types and constants for the 8b10b link sync controller.
// Revision : 1.0
// ============================================================================
package link_sync_pkg;

    typedef enum logic [1:0] {
        LOS       = 2'd0,
        COMMA_DET = 2'd1,
        SYNC      = 2'd2
    } link_state_t;

    localparam int         WORD_W  = 10;
    localparam logic [6:0] COMMA_P = 7'b0011111;
    localparam logic [6:0] COMMA_N = 7'b1100000;

    // Only the leading seven bits identify a K28.5 comma, in either disparity.
    function automatic logic is_comma(input logic [6:0] hi);
        return (hi == COMMA_P) || (hi == COMMA_N);
    endfunction

endpackage
`default_nettype wire

// File: rtl/link_err_mon.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : link_err_mon
// Purpose  : Error / good-word counters that decide when an in-sync link drops.
// Revision : 1.0
// ============================================================================
module link_err_mon #(
    parameter int ERR_TO_LOSE   = 4,
    parameter int GOOD_TO_CLEAR = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clear,
    input  logic       sample,
    input  logic       err,
    output logic       lose,
    output logic [2:0] err_cnt
);

    localparam int             GW        = $clog2(GOOD_TO_CLEAR + 1);
    localparam logic [2:0]     LOSE_LAST = 3'(ERR_TO_LOSE - 1);
    localparam logic [GW-1:0]  GOOD_LAST = GW'(GOOD_TO_CLEAR - 1);

    logic [GW-1:0] good_cnt;

    assign lose = sample && err && (err_cnt == LOSE_LAST);

    // Losing sync also empties the counters so the next lock starts fresh.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_cnt  <= 3'd0;
            good_cnt <= '0;
        end else if (clear || lose) begin
            err_cnt  <= 3'd0;
            good_cnt <= '0;
        end else if (sample) begin
            if (err) begin
                err_cnt  <= err_cnt + 3'd1;
                good_cnt <= '0;
            end else if (good_cnt == GOOD_LAST) begin
                good_cnt <= '0;
                if (err_cnt != 3'd0) begin
                    err_cnt <= err_cnt - 3'd1;
                end
            end else begin
                good_cnt <= good_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/link_sync_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : link_sync_ctrl
// Purpose  : Comma hunting, word framing and link-sync FSM for 8b10b receive.
// Revision : 1.0
// ============================================================================
module link_sync_ctrl
    import link_sync_pkg::*;
#(
    parameter int COMMA_TO_LOCK = 3,
    parameter int ERR_TO_LOSE   = 4,
    parameter int GOOD_TO_CLEAR = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              bit_i,
    input  logic              bit_vld_i,
    input  logic              code_err_i,
    input  logic              disp_err_i,
    output logic [WORD_W-1:0] word_o,
    output logic              word_vld_o,
    output logic              is_comma_o,
    output logic              sync_o,
    output logic [1:0]        state_o,
    output logic [2:0]        err_cnt_o
);

    localparam logic [3:0] LAST_BIT  = 4'(WORD_W - 1);
    localparam logic [2:0] LOCK_LAST = 3'(COMMA_TO_LOCK - 1);

    // Only the nine newest bits need keeping; the tenth is the live input.
    logic [WORD_W-2:0] win_q;
    logic [WORD_W-1:0] win_d;
    logic [3:0]        bit_cnt;
    logic [2:0]        comma_cnt;
    logic              acq_word;
    link_state_t       state;
    logic              comma_hit;
    logic              boundary;
    logic              word_err;
    logic              lose;

    assign win_d     = {win_q, bit_i};
    assign comma_hit = bit_vld_i && is_comma(win_d[WORD_W-1:3]);
    assign boundary  = bit_vld_i && (bit_cnt == LAST_BIT);
    assign word_err  = word_vld_o && (code_err_i || disp_err_i);
    assign state_o   = state;

    link_err_mon #(
        .ERR_TO_LOSE   (ERR_TO_LOSE),
        .GOOD_TO_CLEAR (GOOD_TO_CLEAR)
    ) u_err_mon (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear   (state != SYNC),
        .sample  (word_vld_o && (state == SYNC)),
        .err     (code_err_i || disp_err_i),
        .lose    (lose),
        .err_cnt (err_cnt_o)
    );

    // acq_word marks a word emitted by a hunt/realign hit: its comma was
    // already counted when comma_cnt was loaded with 1.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            win_q      <= '0;
            bit_cnt    <= 4'd0;
            comma_cnt  <= 3'd0;
            acq_word   <= 1'b0;
            word_o     <= '0;
            word_vld_o <= 1'b0;
            is_comma_o <= 1'b0;
            sync_o     <= 1'b0;
            state      <= LOS;
        end else begin
            word_vld_o <= 1'b0;
            if (bit_vld_i) begin
                win_q   <= win_d[WORD_W-2:0];
                bit_cnt <= (bit_cnt == LAST_BIT) ? 4'd0 : bit_cnt + 4'd1;
            end
            if (boundary) begin
                word_o     <= win_d;
                word_vld_o <= 1'b1;
                is_comma_o <= comma_hit;
                acq_word   <= 1'b0;
            end

            case (state)
                LOS: begin
                    sync_o <= 1'b0;
                    if (comma_hit) begin
                        word_o     <= win_d;
                        word_vld_o <= 1'b1;
                        is_comma_o <= 1'b1;
                        acq_word   <= 1'b1;
                        bit_cnt    <= 4'd0;
                        comma_cnt  <= 3'd1;
                        state      <= COMMA_DET;
                    end
                end
                COMMA_DET: begin
                    if (word_err) begin
                        comma_cnt <= 3'd0;
                        state     <= LOS;
                    end else if (comma_hit && (bit_cnt != LAST_BIT)) begin
                        word_o     <= win_d;
                        word_vld_o <= 1'b1;
                        is_comma_o <= 1'b1;
                        acq_word   <= 1'b1;
                        bit_cnt    <= 4'd0;
                        comma_cnt  <= 3'd1;
                    end else if (word_vld_o && is_comma_o && !acq_word) begin
                        comma_cnt <= comma_cnt + 3'd1;
                        if (comma_cnt == LOCK_LAST) begin
                            state  <= SYNC;
                            sync_o <= 1'b1;
                        end
                    end
                end
                SYNC: begin
                    if (lose) begin
                        comma_cnt <= 3'd0;
                        sync_o    <= 1'b0;
                        state     <= LOS;
                    end
                end
                default: begin
                    comma_cnt <= 3'd0;
                    sync_o    <= 1'b0;
                    state     <= LOS;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/link_sync_ctrl.md
# link_sync_ctrl

Word-alignment and link-synchronisation controller for the serial 8b10b receive path. It takes the raw serial bit stream and hunts for K28.5 comma patterns to fix the 10-bit word boundary. It then presents framed words to the external decode_8b10b instance and uses the decoder's code and disparity error flags to declare, keep, or drop link sync. It sits between the serial input pin logic and the decoder, and it sequences when the decoder's output is meaningful.

## Interface
- COMMA_TO_LOCK, default 3: aligned commas needed to declare sync. Legal range 2..7.
- ERR_TO_LOSE, default 4: error count that drops sync. Legal range 1..7.
- GOOD_TO_CLEAR, default 16: consecutive clean words needed to decrement the error count. Must be at least 1.
- clk_i  in  1  clock.
- rst_i  in  1  reset; asynchronous, active-high.
- bit_i  in  1  serial data, MSB of each word first.
- bit_vld_i  in  1  bit_i is valid this cycle.
- code_err_i  in  1  decoder code error for word_o; sampled only while word_vld_o=1.
- disp_err_i  in  1  decoder disparity error for word_o; sampled only while word_vld_o=1.
- word_o  out  10  framed 10-bit word, connected to the decoder datain.
- word_vld_o  out  1  single-cycle strobe that marks a new word_o.
- is_comma_o  out  1  word_o is a comma; registered together with word_o.
- sync_o  out  1  link is in SYNC.
- state_o  out  2  current FSM state.
- err_cnt_o  out  3  current error count.

## Operation
- Shift window: win_d = {win_q[8:0], bit_i}. It shifts only when bit_vld_i=1. Every counter holds while bit_vld_i=0.
- Comma test on win_d: win_d[9:3] is 7'b0011111 or 7'b1100000.
- Word emission: when a word boundary occurs, on that edge word_o <= win_d, word_vld_o <= 1 and is_comma_o <= the comma test. Otherwise word_vld_o <= 0 and word_o holds.
- The bit counter runs 0..9 and wraps. A boundary occurs when bit_cnt = 9 and bit_vld_i = 1.
- An "error word" is one where word_vld_o=1 and (code_err_i or disp_err_i) is 1.
- LOS (state 0):
  - Commas are checked at every valid bit.
  - On a hit: emit the word, set bit_cnt to 0, set comma_cnt to 1, go to COMMA_DET.
  - Decoder errors are ignored in LOS.
- COMMA_DET (state 1), events in priority order:
  1. Error word: go to LOS.
  2. Comma found while bit_cnt != 9: realign by emitting the word, setting bit_cnt to 0 and setting comma_cnt to 1.
  3. Emitted word is a clean comma: increment comma_cnt. When comma_cnt reaches COMMA_TO_LOCK, go to SYNC with err_cnt = 0.
  4. Clean word that is not a comma: comma_cnt holds.
- SYNC (state 2):
  - Alignment is frozen. Off-boundary commas are ignored.
  - Error word: increment err_cnt and clear good_cnt. If the new err_cnt equals ERR_TO_LOSE, go to LOS.
  - Clean word: increment good_cnt. When good_cnt reaches GOOD_TO_CLEAR, clear good_cnt and decrement err_cnt, saturating at 0.
- Entering LOS clears comma_cnt, err_cnt and good_cnt.
- sync_o = (state == SYNC), registered. State encoding 3 is illegal and recovers to LOS.
- Reset mid-operation returns the block to LOS immediately.

## Timing
- Reset values: word_o=0, word_vld_o=0, is_comma_o=0, sync_o=0, state_o=0, err_cnt_o=0. win_q, bit_cnt, comma_cnt and good_cnt are also 0.
- word_vld_o rises in the cycle after the edge that captured the word's last bit.
- code_err_i and disp_err_i are combinational from word_o and are consumed in that same cycle.
- State, counter and sync_o updates take effect on the edge that ends the word_vld_o cycle. This gives one cycle of latency from error flag to state change.
- Bit shifting continues during the word_vld_o cycle. A realign event and an error sample can therefore fall in the same cycle; the COMMA_DET priority list resolves this.
- With bit_vld_i=1 continuously, words arrive every 10 cycles.

## Structure
- Package link_sync_pkg holds:
  - typedef enum logic [1:0] {LOS, COMMA_DET, SYNC};
  - WORD_W = 10;
  - COMMA_P = 7'b0011111 and COMMA_N = 7'b1100000.
- One sub-module, link_err_mon, holds the err_cnt/good_cnt saturating counters. Its inputs are clear, sample and err; its output is lose.

## Test plan
- Reset: assert rst_i mid-stream after sync has been reached. All outputs go to 0 asynchronously and state_o=0 while rst_i is high.
- Acquire:
  - Stimulus: 5 junk bits, then 10'h0FA, 10'h305, 10'h0FA with a clean decoder.
  - word_o is 0FA, 305, 0FA with is_comma_o=1 each time.
  - sync_o rises one cycle after the third word_vld_o; err_cnt_o=0.
- Realign:
  - Stimulus: one aligned 0FA, 4 junk bits, then 0FA, 305, 0FA.
  - Realign occurs at the shifted comma; sync_o rises only after the third shifted comma.
- Loss:
  - Stimulus: in SYNC, drive 4 consecutive error words with 10'h2AA data.
  - err_cnt_o steps 1, 2, 3; after the fourth error word, state_o=0, sync_o=0 and err_cnt_o=0.
- Recovery:
  - Stimulus: 3 error words, then 16 clean words.
  - err_cnt_o goes from 3 to 2, then to 1 after another 16 clean words; sync_o stays 1 throughout.
- Gapped input: toggle bit_vld_i every other cycle during acquire. Words are identical to the Acquire case and word_vld_o spacing is 20 cycles.
